// File: rtl/fetch_stage_if.sv
// Handshake bundle between the IF stage, the instruction memory and the ID stage.
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_stage_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_addr_o;
    logic [31:0] inst_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_bubble_o;
`endif

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, inst_i,
`ifdef FETCH_PERF_EN
        output perf_fetch_o, perf_bubble_o,
`endif
        output instr_addr_o, if_pc_o, if_pc4_o, if_inst_o, if_valid_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, inst_i,
`ifdef FETCH_PERF_EN
        input  perf_fetch_o, perf_bubble_o,
`endif
        input  instr_addr_o, if_pc_o, if_pc4_o, if_inst_o, if_valid_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, tags the 1-cycle-latency memory word, and holds
// it across ID stalls. Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        req_vld_q;
    logic [31:0] hold_q;

    assign bus.instr_addr_o = pc_q;
    assign bus.if_pc_o      = req_pc_q;
    assign bus.if_pc4_o     = req_pc_q + 32'd4;
    assign bus.if_inst_o    = (state_q == StHold) ? hold_q : bus.inst_i;
    assign bus.if_valid_o   = req_vld_q & ~bus.redirect_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            req_vld_q <= 1'b0;
            hold_q    <= 32'h0;
            state_q   <= StFetch;
        end else if (bus.redirect_i) begin
            // The word arriving now belongs to the wrong path; req_vld_q kills it.
            pc_q      <= {bus.redirect_pc_i[31:2], 2'b00};
            req_pc_q  <= pc_q;
            req_vld_q <= 1'b0;
            state_q   <= StFetch;
        end else if (bus.stall_i) begin
            // Capture the word only on stall entry; memory keeps re-reading pc_q meanwhile.
            if (state_q == StFetch) begin
                hold_q  <= bus.inst_i;
                state_q <= StHold;
            end
        end else begin
            req_pc_q  <= pc_q;
            req_vld_q <= 1'b1;
            pc_q      <= pc_q + 32'd4;
            state_q   <= StFetch;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q  <= 32'h0;
            perf_bubble_q <= 32'h0;
        end else begin
            if (bus.if_valid_o && !bus.stall_i) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (!bus.if_valid_o) perf_bubble_q <= perf_bubble_q + 32'd1;
        end
    end

    assign bus.perf_fetch_o  = perf_fetch_q;
    assign bus.perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a stream-level model predicts accepted {pc, inst} beats
// and bubble cycles; a negedge monitor pops and compares whatever the DUT hands to ID.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory image: odd multiplier makes every word address map to a distinct value.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) bus.inst_i <= memf(bus.instr_addr_o);

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] pc;
        logic [31:0] inst;
    } beat_t;

    beat_t       q[$];
    int unsigned vectors = 0;
    int unsigned errors  = 0;
    logic [31:0] cyc     = 0;
    logic [31:0] m_next;
    int          m_dead;
    logic        exp_v;
    logic        skip_v;
    logic        prev_r;
    logic        mon_en  = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] m_pf, m_pb;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled mid-cycle, after stimulus and model have settled.
    always @(negedge clk) begin
        beat_t b;
        if (mon_en) begin
            if (!skip_v) chk("valid", {31'b0, bus.if_valid_o}, {31'b0, exp_v});
            if (rst) begin
                if (!skip_v) begin
                    chk("rst_addr", bus.instr_addr_o, RST_PC);
                    chk("rst_pc", bus.if_pc_o, RST_PC);
                end
            end else if (bus.if_valid_o && !bus.stall_i) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_beat: got pc %h expected no beat (cycle %0d)",
                             bus.if_pc_o, cyc);
                end else begin
                    b = q.pop_front();
                    chk("beat_cycle", cyc, b.tag);
                    chk("beat_pc", bus.if_pc_o, b.pc);
                    chk("beat_pc4", bus.if_pc4_o, b.pc + 32'd4);
                    chk("beat_inst", bus.if_inst_o, b.inst);
                end
            end else if (bus.if_valid_o) begin
                chk("stall_pc", bus.if_pc_o, m_next);
                chk("stall_inst", bus.if_inst_o, memf(m_next));
            end
        end
    end

    // One cycle of stimulus; the model works on the delivered instruction stream only.
    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] tgt);
        rst               = r;
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = tgt;
        skip_v            = r && !prev_r;
        prev_r            = r;
        if (r) begin
            m_next = RST_PC;
            m_dead = 1;
            exp_v  = 1'b0;
            q.delete();
        end else begin
            exp_v = (m_dead == 0) && !rd;
            if (rd) begin
                m_next = tgt & ~32'd3;
                m_dead = 1;
            end else if (!st) begin
                if (exp_v) begin
                    q.push_back('{tag: cyc, pc: m_next, inst: memf(m_next)});
                    m_next = m_next + 32'd4;
                end else begin
                    m_dead--;
                end
            end
        end
`ifdef FETCH_PERF_EN
        if (r) begin
            m_pf = 0;
            m_pb = 0;
        end else begin
            if (exp_v && !st) m_pf = m_pf + 32'd1;
            if (!exp_v) m_pb = m_pb + 32'd1;
        end
`endif
        @(posedge clk);
        #1;
        cyc = cyc + 32'd1;
`ifdef FETCH_PERF_EN
        chk("perf_fetch", bus.perf_fetch_o, m_pf);
        chk("perf_bubble", bus.perf_bubble_o, m_pb);
`endif
    endtask

    initial begin
        logic r, st, rd;
        logic [31:0] tgt;
        int rlen;
        rst               = 1'b1;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        m_next            = RST_PC;
        m_dead            = 1;
        exp_v             = 1'b0;
        skip_v            = 1'b0;
        prev_r            = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        // Straight line up to the point where 0x10 is on the IF output.
        for (int i = 0; i < 40 && !(m_dead == 0 && m_next == 32'h10); i++)
            step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Redirect to a misaligned target.
        step(1'b0, 1'b0, 1'b1, 32'h0000_004E);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Redirect inside a stall; held word must vanish.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0070);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Back-to-back redirects, then wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                rlen = $urandom_range(1, 3);
                for (int k = 0; k < rlen; k++)
                    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
            r   = 1'b0;
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 8);
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step(r, st, rd, tgt);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);

        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding expected 0", q.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
